// File: rtl/scr1_dmem_router_n_if.sv
// Core-side dmem bus of the SCR1 data-memory router.
// The core drives requests through the master modport; the router serves the slave side.
interface scr1_dmem_router_n_if;
   logic        dmem_req;
   logic        dmem_cmd;
   logic [1:0]  dmem_width;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_req_ack;
   logic [31:0] dmem_rdata;
   logic [1:0]  dmem_resp;

   modport master (
      output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      input  dmem_req_ack, dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      output dmem_req_ack, dmem_rdata, dmem_resp
   );
endinterface

// File: rtl/scr1_dmem_router_n.sv
// Routes one outstanding SCR1 dmem transaction to one of N slave ports by base/mask window,
// answering unmapped, misaligned and timed-out accesses with its own ERROR response.
module scr1_dmem_router_n #(
   parameter int unsigned             N_PORTS   = 2,
   parameter logic [N_PORTS*32-1:0]   PORT_BASE = {32'h0001_0000, 32'h0000_0000},
   parameter logic [N_PORTS*32-1:0]   PORT_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
   parameter int unsigned             TIMEOUT   = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   scr1_dmem_router_n_if.slave      bus,
   output logic [N_PORTS-1:0]       port_req_o,
   output logic                     port_cmd_o,
   output logic [1:0]               port_width_o,
   output logic [31:0]              port_addr_o,
   output logic [31:0]              port_wdata_o,
   input  logic [N_PORTS-1:0]       port_req_ack_i,
   input  logic [N_PORTS*32-1:0]    port_rdata_i,
   input  logic [N_PORTS*2-1:0]     port_resp_i,
   output logic [15:0]              err_cnt_o
);

   localparam logic [1:0] RESP_IDLE  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b10;

   localparam int unsigned    TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [2:0]           sel_q, sel_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [15:0]          err_cnt_q, err_cnt_d;

   logic                 hit;
   logic [2:0]           hit_idx;
   logic [N_PORTS-1:0]   hit_oh;
   logic                 aligned;
   logic [1:0]           sel_resp;
   logic [31:0]          sel_rdata;
   logic [N_PORTS-1:0]   port_req;
   logic                 req_ack;
   logic [1:0]           resp;
   logic [31:0]          rdata;

   // Walk from the highest index down so the lowest matching window is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_oh  = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if ((bus.dmem_addr & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]) begin
            hit       = 1'b1;
            hit_idx   = 3'(i);
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      case (bus.dmem_width)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~bus.dmem_addr[0];
         2'd2:    aligned = (bus.dmem_addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      sel_resp  = RESP_IDLE;
      sel_rdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (sel_q == 3'(i)) begin
            sel_resp  = port_resp_i[2*i +: 2];
            sel_rdata = port_rdata_i[32*i +: 32];
         end
      end
   end

   always_comb begin
      // NOTE: every next-state and output gets a default first, so no branch can infer a latch.
      state_d  = state_q;
      sel_d    = sel_q;
      tmo_d    = tmo_q;
      port_req = '0;
      req_ack  = 1'b0;
      resp     = RESP_IDLE;
      rdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.dmem_req) begin
               if (hit && aligned) begin
                  port_req = hit_oh;
                  req_ack  = |(hit_oh & port_req_ack_i);
                  if (req_ack) begin
                     sel_d   = hit_idx;
                     tmo_d   = '0;
                     state_d = ST_WAIT;
                  end
               end else begin
                  req_ack = 1'b1;
                  state_d = ST_ERR;
               end
            end
         end
         ST_WAIT: begin
            resp  = sel_resp;
            rdata = sel_rdata;
            if (sel_resp != RESP_IDLE) begin
               state_d = ST_IDLE;
            end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
               state_d = ST_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_ERR: begin
            resp    = RESP_ERROR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign err_cnt_d = ((resp == RESP_ERROR) && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1
                                                                        : err_cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         tmo_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         tmo_q     <= tmo_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.dmem_req_ack = req_ack;
   assign bus.dmem_resp    = resp;
   assign bus.dmem_rdata   = rdata;

   assign port_req_o   = port_req;
   assign port_cmd_o   = bus.dmem_cmd;
   assign port_width_o = bus.dmem_width;
   assign port_addr_o  = bus.dmem_addr;
   assign port_wdata_o = bus.dmem_wdata;
   assign err_cnt_o    = err_cnt_q;

endmodule
